// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC acknowledge sequencer.
// Levels are 3 bits; priority rotates from a movable base level.
package pic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PEND,
      ACK1,
      WAIT2,
      ACK2
   } state_t;

   typedef logic [2:0] level_t;

   localparam level_t SPURIOUS_LEVEL = 3'd7;

   function automatic logic [7:0] onehot(level_t l);
      onehot = 8'b1 << l;
   endfunction

   // Scan from lowest to highest priority so the best hit wins.
   function automatic logic [3:0] rot_pick(
      logic [7:0] bits,
      level_t     base
   );
      level_t idx;
      rot_pick = '0;
      for (int k = 7; k >= 0; k--) begin
         idx = base + level_t'(k);
         if (bits[idx]) rot_pick = {1'b1, idx};
      end
   endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Picks the best eligible level and the best in-service level
// relative to the rotating priority base (fully nested compare).
module pic_priority_resolver (
   input  logic [7:0] eligible_i,
   input  logic [7:0] isr_i,
   input  logic [2:0] pri_base_i,
   output logic       cand_valid_o,
   output logic [2:0] cand_level_o,
   output logic       isr_valid_o,
   output logic [2:0] isr_level_o
);
   import pic_pkg::*;

   logic [3:0] e_pick;
   logic [3:0] i_pick;
   level_t     e_rank;
   level_t     i_rank;

   always_comb begin
      e_pick = rot_pick(eligible_i, pri_base_i);
      i_pick = rot_pick(isr_i, pri_base_i);
      // Rank 0 is the highest priority.
      e_rank = e_pick[2:0] - pri_base_i;
      i_rank = i_pick[2:0] - pri_base_i;
      cand_valid_o = e_pick[3] &
                     (~i_pick[3] | (e_rank < i_rank));
      cand_level_o = e_pick[2:0];
      isr_valid_o  = i_pick[3];
      isr_level_o  = i_pick[2:0];
   end

endmodule

// File: rtl/pic_ack_sequencer.sv
// INT/INTA handshake, in-service tracking, EOI and rotation
// for the PIC core.
module pic_ack_sequencer #(
   parameter int         NUM_LEVELS     = 8,
   parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_LEVELS-1:0] irr,
   input  logic [NUM_LEVELS-1:0] imr,
   input  logic                  inta_n,
   input  logic                  eoi,
   input  logic                  seoi,
   input  logic [2:0]            seoi_level,
   input  logic                  aeoi_mode,
   input  logic                  rotate_on_eoi,
   output logic                  int_out,
   output logic [NUM_LEVELS-1:0] clr_irr,
   output logic [NUM_LEVELS-1:0] isr,
   output logic                  vector_valid,
   output logic [2:0]            vector_level
);
   import pic_pkg::*;

   state_t     state_q, state_d;
   logic       inta_q;
   level_t     lvl_q, lvl_d;
   logic       spur_q, spur_d;
   logic [7:0] isr_q, isr_d;
   level_t     base_q, base_d;
   logic       int_q, int_d;
   logic [7:0] clr_q, clr_d;
   logic       vv_q, vv_d;
   level_t     vl_q, vl_d;

   logic       fall, rise, take;
   logic       cand_valid, isr_valid;
   level_t     cand_level, isr_level;
   logic       eoi_hit, aeoi_done;
   level_t     eoi_lvl;
   logic [7:0] set_mask, clr_mask;

   assign fall = inta_q & ~inta_n;
   assign rise = ~inta_q & inta_n;

   pic_priority_resolver u_res (
      .eligible_i   (irr & ~imr),
      .isr_i        (isr_q),
      .pri_base_i   (base_q),
      .cand_valid_o (cand_valid),
      .cand_level_o (cand_level),
      .isr_valid_o  (isr_valid),
      .isr_level_o  (isr_level)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         inta_q  <= 1'b1;
         lvl_q   <= '0;
         spur_q  <= 1'b0;
         isr_q   <= '0;
         base_q  <= '0;
         int_q   <= 1'b0;
         clr_q   <= '0;
         vv_q    <= 1'b0;
         vl_q    <= '0;
      end else begin
         state_q <= state_d;
         inta_q  <= inta_n;
         lvl_q   <= lvl_d;
         spur_q  <= spur_d;
         isr_q   <= isr_d;
         base_q  <= base_d;
         int_q   <= int_d;
         clr_q   <= clr_d;
         vv_q    <= vv_d;
         vl_q    <= vl_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (fall) state_d = ACK1;
                else if (cand_valid) state_d = PEND;
         PEND:  if (fall) state_d = ACK1;
                else if (!cand_valid) state_d = IDLE;
         ACK1:  if (rise) state_d = WAIT2;
         WAIT2: if (fall) state_d = ACK2;
         ACK2:  if (rise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      take = fall & ((state_q == IDLE) | (state_q == PEND));
      lvl_d  = lvl_q;
      spur_d = spur_q;
      if (take) begin
         lvl_d  = cand_valid ? cand_level : SPURIOUS_LEVEL;
         spur_d = ~cand_valid;
      end
      set_mask = (take & cand_valid) ? onehot(cand_level) : 8'h00;
      aeoi_done = (state_q == ACK2) & rise & aeoi_mode & ~spur_q;
      // Specific EOI takes precedence over non-specific.
      eoi_hit = 1'b0;
      eoi_lvl = '0;
      if (seoi) begin
         eoi_hit = isr_q[seoi_level];
         eoi_lvl = seoi_level;
      end else if (eoi) begin
         eoi_hit = isr_valid;
         eoi_lvl = isr_level;
      end
      clr_mask = (eoi_hit ? onehot(eoi_lvl) : 8'h00) |
                 (aeoi_done ? onehot(lvl_q) : 8'h00);
      isr_d = (isr_q & ~clr_mask) | set_mask;
      base_d = base_q;
      if (rotate_on_eoi & eoi_hit)
         base_d = eoi_lvl + 3'd1;
      else if (rotate_on_eoi & aeoi_done)
         base_d = lvl_q + 3'd1;
   end

   always_comb begin
      int_d = (state_d == PEND);
      clr_d = set_mask;
      vv_d  = (state_d == ACK2);
      vl_d  = (state_d == ACK2) ? lvl_d : vl_q;
   end

   assign int_out      = int_q;
   assign clr_irr      = clr_q;
   assign isr          = isr_q;
   assign vector_valid = vv_q;
   assign vector_level = vl_q;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Randomized bench for pic_ack_sequencer against a
// transaction-level model of the PIC priority rules.
module tb_pic_ack_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] irr, imr;
   logic       inta_n, eoi, seoi;
   logic [2:0] seoi_level;
   logic       aeoi_mode, rotate_on_eoi;
   logic       int_out, vector_valid;
   logic [7:0] clr_irr, isr;
   logic [2:0] vector_level;

   int checks = 0;
   int failures = 0;

   logic [7:0] m_isr;
   int         m_base;
   int         got;

   always #5 clk = ~clk;

   pic_ack_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .irr           (irr),
      .imr           (imr),
      .inta_n        (inta_n),
      .eoi           (eoi),
      .seoi          (seoi),
      .seoi_level    (seoi_level),
      .aeoi_mode     (aeoi_mode),
      .rotate_on_eoi (rotate_on_eoi),
      .int_out       (int_out),
      .clr_irr       (clr_irr),
      .isr           (isr),
      .vector_valid  (vector_valid),
      .vector_level  (vector_level)
   );

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Walk levels in priority order: an in-service level met
   // first blocks everything below it.
   function automatic int m_pick();
      int l;
      for (int k = 0; k < 8; k++) begin
         l = (m_base + k) % 8;
         if (m_isr[l]) return -1;
         if (irr[l] && !imr[l]) return l;
      end
      return -1;
   endfunction

   function automatic int m_top_isr();
      int l;
      for (int k = 0; k < 8; k++) begin
         l = (m_base + k) % 8;
         if (m_isr[l]) return l;
      end
      return -1;
   endfunction

   task automatic settle();
      step();
      step();
      chk("int_out", 32'(int_out), 32'(m_pick() >= 0));
   endtask

   task automatic do_ack(input logic aeoi_v, output int lvl);
      int         c;
      logic [7:0] e;
      aeoi_mode = aeoi_v;
      c = m_pick();
      e = (c >= 0) ? 8'(1 << c) : 8'h00;
      inta_n = 1'b0;
      step();
      chk("clr_irr", 32'(clr_irr), 32'(e));
      chk("int_ack1", 32'(int_out), 0);
      m_isr = m_isr | e;
      chk("isr_set", 32'(isr), 32'(m_isr));
      irr = irr & ~e;
      step();
      chk("clr_one", 32'(clr_irr), 0);
      inta_n = 1'b1;
      step();
      inta_n = 1'b0;
      step();
      chk("vv", 32'(vector_valid), 1);
      chk("vlevel", 32'(vector_level), (c >= 0) ? c : 7);
      lvl = int'(vector_level);
      inta_n = 1'b1;
      step();
      chk("vv_off", 32'(vector_valid), 0);
      if (aeoi_v && c >= 0) begin
         m_isr[c] = 1'b0;
         if (rotate_on_eoi) m_base = (c + 1) % 8;
      end
      chk("isr_ack", 32'(isr), 32'(m_isr));
   endtask

   task automatic do_eoi(input logic spec, input int lvl);
      int cl;
      if (spec) cl = m_isr[lvl] ? lvl : -1;
      else cl = m_top_isr();
      eoi = ~spec;
      seoi = spec;
      seoi_level = 3'(lvl);
      step();
      eoi = 1'b0;
      seoi = 1'b0;
      if (cl >= 0) begin
         m_isr[cl] = 1'b0;
         if (rotate_on_eoi) m_base = (cl + 1) % 8;
      end
      chk("isr_eoi", 32'(isr), 32'(m_isr));
   endtask

   initial begin
      rst_n = 1'b0;
      irr = '0;
      imr = '0;
      inta_n = 1'b1;
      eoi = 1'b0;
      seoi = 1'b0;
      seoi_level = '0;
      aeoi_mode = 1'b0;
      rotate_on_eoi = 1'b0;
      m_isr = '0;
      m_base = 0;
      step();
      step();
      chk("rst_int", 32'(int_out), 0);
      chk("rst_isr", 32'(isr), 0);
      chk("rst_clr", 32'(clr_irr), 0);
      chk("rst_vv", 32'(vector_valid), 0);
      chk("rst_vl", 32'(vector_level), 0);
      rst_n = 1'b1;

      irr = 8'h24;
      settle();
      chk("t1_int", 32'(int_out), 1);
      do_ack(1'b0, got);
      chk("t1_lvl", got, 2);
      chk("t1_isr", 32'(isr), 32'h04);

      irr = irr | 8'h02;
      settle();
      do_ack(1'b0, got);
      chk("nest_isr", 32'(isr), 32'h06);
      settle();
      chk("nest_blk", 32'(int_out), 0);
      do_eoi(1'b0, 0);
      settle();
      chk("blk5", 32'(int_out), 0);
      do_eoi(1'b1, 2);
      settle();
      do_ack(1'b0, got);
      chk("lvl5", got, 5);
      do_eoi(1'b1, 5);
      do_eoi(1'b1, 5);

      rotate_on_eoi = 1'b1;
      irr = 8'h08;
      settle();
      do_ack(1'b0, got);
      chk("rot_isr", 32'(isr), 32'h08);
      do_eoi(1'b0, 0);
      chk("rot_clr", 32'(isr), 0);
      rotate_on_eoi = 1'b0;
      irr = 8'h11;
      settle();
      do_ack(1'b0, got);
      chk("rot_first", got, 4);
      do_eoi(1'b0, 0);
      settle();
      do_ack(1'b0, got);
      chk("rot_second", got, 0);
      do_eoi(1'b0, 0);

      irr = 8'h01;
      settle();
      chk("mask_int", 32'(int_out), 1);
      imr = 8'h01;
      step();
      chk("mask_drop", 32'(int_out), 0);
      do_ack(1'b0, got);
      chk("spur_lvl", got, 7);
      irr = '0;
      imr = '0;

      irr = 8'h80;
      settle();
      do_ack(1'b1, got);
      chk("aeoi_isr", 32'(isr), 0);
      aeoi_mode = 1'b0;

      irr = 8'h10;
      settle();
      inta_n = 1'b0;
      step();
      chk("pre_rst_isr", 32'(isr), 32'h10);
      irr = '0;
      inta_n = 1'b1;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_isr", 32'(isr), 0);
      chk("arst_int", 32'(int_out), 0);
      chk("arst_vv", 32'(vector_valid), 0);
      chk("arst_clr", 32'(clr_irr), 0);
      m_isr = '0;
      m_base = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      do_ack(1'b0, got);
      chk("post_rst", got, 7);

      for (int i = 0; i < 80; i++) begin
         rotate_on_eoi = 1'($urandom);
         case ($urandom_range(0, 3))
            0, 1: begin
               irr = irr | 8'($urandom);
               imr = 8'($urandom) & 8'($urandom);
               settle();
               do_ack(1'($urandom), got);
            end
            2: do_eoi(1'b0, 0);
            default: do_eoi(1'b1, $urandom_range(0, 7));
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/pic_ack_sequencer.md
# pic_ack_sequencer

Interrupt acknowledge sequencer and priority controller for the PIC core. It picks the highest-priority unmasked pending request, raises INT, and runs the two-pulse INTA handshake. It maintains the in-service register (ISR) and handles non-specific, specific and automatic EOI, with optional rotate-on-EOI. It sits between the request register and mask register on one side and the CPU bus/vector logic on the other.

## Interface
Parameters:
- NUM_LEVELS, 8, interrupt levels (fixed at 8; level index is 3 bits)
- SPURIOUS_LEVEL, 3'd7, level reported when INTA arrives with nothing eligible

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  reset, asynchronous, active-low
- irr  in  8  pending request bits, one per level
- imr  in  8  mask bits; 1 = level masked
- inta_n  in  1  CPU acknowledge, active-low, already synchronous to clk
- eoi  in  1  one-cycle pulse, non-specific EOI
- seoi  in  1  one-cycle pulse, specific EOI
- seoi_level  in  3  level cleared by seoi
- aeoi_mode  in  1  1 = auto EOI at end of second INTA
- rotate_on_eoi  in  1  1 = any EOI also rotates priority
- int_out  out  1  interrupt request to CPU
- clr_irr  out  8  one-hot, one-cycle pulse clearing the acknowledged IRR bit
- isr  out  8  in-service register
- vector_valid  out  1  high while the second INTA is low; vector logic drives the bus
- vector_level  out  3  level encoded into the vector

## Operation
- Priority: pri_base (3-bit register) is the highest-priority level; priority falls as (pri_base+k) mod 8 for k=0..7. Reset value is 0, so level 0 is highest.
- Eligible set = irr & ~imr. The candidate is the highest-priority eligible level, and it must have strictly higher priority than the highest set ISR bit (fully nested).
- FSM states and transitions:
  - IDLE: int_out=0. Go to PEND when a candidate exists.
  - PEND: int_out=1. Go back to IDLE if the candidate disappears. On an inta_n fall, go to ACK1.
  - ACK1: int_out=0. On an inta_n rise, go to WAIT2.
  - WAIT2: on an inta_n fall, go to ACK2.
  - ACK2: vector_valid=1. On an inta_n rise, go to IDLE.
- inta_n edge detect uses registered inta_q: fall = inta_q & ~inta_n; rise = ~inta_q & inta_n.
- First INTA fall (from PEND, or from IDLE when nothing is eligible):
  - The candidate level is latched into lvl_q.
  - isr[lvl_q] is set and clr_irr pulses onehot(lvl_q) for exactly one cycle.
  - If there is no candidate, lvl_q = SPURIOUS_LEVEL, with no ISR set and no clr_irr.
- ACK2: vector_level = lvl_q. On leaving ACK2 with aeoi_mode=1 and a non-spurious level, isr[lvl_q] clears. If rotate_on_eoi=1, pri_base also becomes lvl_q+1 (mod 8).
- Non-specific EOI clears the highest-priority set ISR bit. Specific EOI clears isr[seoi_level].
- On any EOI with rotate_on_eoi=1: pri_base = cleared level + 1 (mod 8).
- EOI with nothing to clear (ISR empty, or the named bit already clear) is a no-op; pri_base is unchanged.
- eoi and seoi in the same cycle: seoi wins.
- An EOI cycle that coincides with an ISR set applies in this order: isr_next = (isr & ~clear) | set.
- Mask or irr changes during ACK1/WAIT2/ACK2 do not affect lvl_q.

## Timing
- Reset values: int_out=0, clr_irr=0, isr=0, vector_valid=0, vector_level=0, pri_base=0, inta_q=1, state IDLE.
- Outputs are registered; int_out rises one cycle after a candidate appears.
- clr_irr and the ISR set are visible in the cycle after the first-INTA fall sample. int_out is 0 in that same cycle.
- vector_valid/vector_level are valid from the cycle after the second fall sample through the cycle the rise is sampled.
- EOI takes effect on isr one cycle after the pulse.
- Reset mid-handshake returns to IDLE immediately; any following INTA is then treated as spurious.

## Structure
- Package pic_pkg holds:
  - the state enum (IDLE, PEND, ACK1, WAIT2, ACK2);
  - the level_t 3-bit typedef and SPURIOUS_LEVEL;
  - function onehot(level_t) returning 8 bits;
  - function rot_pick(bits, base) returning {found, level}.
- One sub-module: pic_priority_resolver, combinational. Inputs: eligible, isr, pri_base. Outputs: candidate valid/level and the highest ISR level for non-specific EOI.

## Test plan
- Reset, then irr=8'h24, imr=0, two INTA pulses → int_out=1; clr_irr=8'h04 for one cycle; isr=8'h04; vector_level=2.
- isr=8'h04 and irr bit 1 set → second interrupt nests (isr=8'h06). With isr=8'h04, irr bit 5 set → int_out stays 0.
- rotate_on_eoi=1, isr=8'h08, eoi pulse → isr=0 and pri_base=4. Then irr=8'h11 → level 4 is acknowledged before 0.
- irr=8'h01 gives int_out=1, then imr=8'h01 before INTA → int_out drops. INTA pair then gives vector_level=7, isr unchanged, clr_irr=0.
- aeoi_mode=1, irr=8'h80 → after the second INTA rise, isr returns to 0 with no EOI.
- rst_n asserted in WAIT2 with isr=8'h10 → all outputs return to reset values asynchronously.
